// File: rtl/aes_serial_rx.sv
// aes_serial_rx -- deserialising receiver for the single-wire AES ciphertext link.
//
// The transmitter marks each new bit by toggling ser_strobe (either direction),
// LSB first. Both async lines are synchronised, each strobe edge launches a
// settle timer, and the synchronised data is sampled when the timer expires.
// NBITS samples form a block that is offered on a valid/ready handshake.
//
// Ports:
//   clk, rst_n   clock, async active-low reset
//   ser_data     serial data bit (async)
//   ser_strobe   bit strobe (async), every toggle = one bit
//   blk_data     assembled block, bit i = i-th received bit
//   blk_valid    block available, held until accepted
//   blk_ready    consumer accept
//   busy         frame in progress (SHIFT or DRAIN)
//   frame_err    1-cycle pulse: truncated frame or strobe glitch
//   overrun      1-cycle pulse: completed frame dropped, output register full
module aes_serial_rx #(
  parameter int NBITS       = 128,
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE      = 4,
  parameter int GAP_CYC     = 120000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ser_data,
  input  logic             ser_strobe,
  output logic [NBITS-1:0] blk_data,
  output logic             blk_valid,
  input  logic             blk_ready,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun
);

  localparam int CW = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam int SW = $clog2(SETTLE + 1);
  localparam logic [CW-1:0] LAST_BIT  = CW'(NBITS - 1);
  localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE - 1);
  localparam logic [31:0]   GAP       = 32'(GAP_CYC);

  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN} state_e;

  // Synchronisers plus one extra strobe flop for edge detection.
  logic [SYNC_STAGES-1:0] data_sync_q, strb_sync_q;
  logic                   strb_dly_q;
  logic                   edge_det, data_s;

  state_e            state_q;
  logic [NBITS-1:0]  shift_q, full_blk_d;
  logic [CW-1:0]     bit_cnt_q;
  logic [SW-1:0]     settle_cnt_q;
  logic              settle_act_q;
  logic [31:0]       gap_q;
  logic [NBITS-1:0]  blk_data_q;
  logic              blk_valid_q, frame_err_q, overrun_q;

  assign edge_det = strb_sync_q[SYNC_STAGES-1] ^ strb_dly_q;
  assign data_s   = data_sync_q[SYNC_STAGES-1];

  // Shift register with the bit being sampled this cycle merged in; used
  // both for the normal update and for loading the output on completion.
  always_comb begin
    full_blk_d            = shift_q;
    full_blk_d[bit_cnt_q] = data_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_sync_q  <= '0;
      strb_sync_q  <= '0;
      strb_dly_q   <= 1'b0;
    end else begin
      data_sync_q  <= {data_sync_q[SYNC_STAGES-2:0], ser_data};
      strb_sync_q  <= {strb_sync_q[SYNC_STAGES-2:0], ser_strobe};
      strb_dly_q   <= strb_sync_q[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      settle_cnt_q <= '0;
      settle_act_q <= 1'b0;
      gap_q        <= '0;
      blk_data_q   <= '0;
      blk_valid_q  <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;

      // Acceptance; a load later in this block overrides it (accept+load).
      if (blk_valid_q && blk_ready) blk_valid_q <= 1'b0;

      // Gap counter: cleared by edges, saturating otherwise.
      if (edge_det)          gap_q <= '0;
      else if (gap_q != GAP) gap_q <= gap_q + 32'd1;

      if (settle_act_q && settle_cnt_q != '0) settle_cnt_q <= settle_cnt_q - 1'b1;

      case (state_q)
        IDLE: begin
          shift_q      <= '0;
          bit_cnt_q    <= '0;
          settle_act_q <= 1'b0;
          if (edge_det) begin
            state_q      <= SHIFT;
            settle_act_q <= 1'b1;
            settle_cnt_q <= SETTLE_LD;
          end
        end

        SHIFT: begin
          if (edge_det && settle_act_q) begin
            // Second edge before the pending sample: strobe glitch.
            frame_err_q  <= 1'b1;
            settle_act_q <= 1'b0;
            state_q      <= IDLE;
          end else if (edge_det) begin
            settle_act_q <= 1'b1;
            settle_cnt_q <= SETTLE_LD;
          end else if (settle_act_q && settle_cnt_q == '0) begin
            settle_act_q <= 1'b0;
            shift_q      <= full_blk_d;
            bit_cnt_q    <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == LAST_BIT) begin
              if (!blk_valid_q || blk_ready) begin
                blk_data_q  <= full_blk_d;
                blk_valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
              state_q <= DRAIN;
            end
          end else if (gap_q == GAP) begin
            frame_err_q <= 1'b1;
            state_q     <= IDLE;
          end
        end

        DRAIN: begin
          // Trailing strobe activity is ignored until the line goes quiet.
          settle_act_q <= 1'b0;
          if (gap_q == GAP) state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign blk_data  = blk_data_q;
  assign blk_valid = blk_valid_q;
  assign busy      = (state_q != IDLE);
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_aes_serial_rx.sv
module tb_aes_serial_rx;
  localparam int NB  = 128;
  localparam int SS  = 2;
  localparam int ST  = 4;
  localparam int GAP = 64;
  localparam int SP  = 20;

  logic clk = 1'b0, rst_n = 1'b1;
  logic ser_data = 1'b0, ser_strobe = 1'b0, blk_ready = 1'b0;
  logic [NB-1:0] blk_data;
  logic blk_valid, busy, frame_err, overrun;

  always #5 clk = ~clk;

  aes_serial_rx #(.NBITS(NB), .SYNC_STAGES(SS), .SETTLE(ST), .GAP_CYC(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .ser_data(ser_data), .ser_strobe(ser_strobe),
    .blk_data(blk_data), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .busy(busy), .frame_err(frame_err), .overrun(overrun)
  );

  int n_chk = 0, n_pass = 0;

  // Monitor: observed handshake traffic and pulses, sampled on negedge.
  int cyc = 0, valid_cyc = 0, ferr_n = 0, ovr_n = 0, stab_err = 0, ferr_cyc = -1;
  logic [NB-1:0] acc_q[$];
  logic [NB-1:0] exp_q[$];
  logic pv = 1'b0, pacc = 1'b0;
  logic [NB-1:0] pd = '0;

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (blk_valid) valid_cyc++;
      if (blk_valid && blk_ready) acc_q.push_back(blk_data);
      if (frame_err) begin ferr_n++; ferr_cyc = cyc; end
      if (overrun) ovr_n++;
      if (blk_valid && pv && !pacc && blk_data !== pd) stab_err++;
    end
    pv = blk_valid; pacc = blk_valid && blk_ready; pd = blk_data;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    valid_cyc = 0; ferr_n = 0; ovr_n = 0; stab_err = 0; ferr_cyc = -1;
    acc_q.delete(); exp_q.delete();
  endtask

  function automatic logic [NB-1:0] rnd_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic send_bit(input logic b);
    ser_data = b;
    ser_strobe = ~ser_strobe;
    tick(SP);
  endtask

  task automatic send_bits(input logic [NB-1:0] v, input int n);
    for (int i = 0; i < n; i++) send_bit(v[i]);
  endtask

  // Full frame, the undefined 129th toggle, then enough quiet to leave DRAIN.
  task automatic send_frame(input logic [NB-1:0] v);
    send_bits(v, NB);
    send_bit(1'($urandom_range(0, 1)));
    tick(GAP + 20);
  endtask

  task automatic accept_one();
    blk_ready = 1'b1;
    tick(1);
    blk_ready = 1'b0;
    tick(2);
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    tick(3);
    n_chk++; if (blk_data !== '0) $display("FAIL reset_data: got %h want 0", blk_data); else n_pass++;
    n_chk++; if (blk_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", blk_valid); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_chk++; if (frame_err !== 1'b0 || overrun !== 1'b0)
      $display("FAIL reset_pulses: got ferr=%b ovr=%b want 0 0", frame_err, overrun); else n_pass++;
    rst_n = 1'b1;
    tick(3);
  endtask

  task automatic test_nominal();
    logic [NB-1:0] k;
    k = 128'h3925841D02DC09FBDC118597196A0B32;
    clear_mon();
    blk_ready = 1'b1;
    exp_q.push_back(k);
    send_bits(k, NB);
    send_bit(1'($urandom_range(0, 1)));
    tick(30);
    n_chk++; if (busy !== 1'b1) $display("FAIL nom_busy_hold: got %b want 1", busy); else n_pass++;
    tick(30);
    n_chk++; if (busy !== 1'b0) $display("FAIL nom_busy_fall: got %b want 0", busy); else n_pass++;
    n_chk++; if (acc_q.size() != 1 || acc_q[0] !== exp_q[0])
      $display("FAIL nom_data: got n=%0d %h want 1 %h", acc_q.size(), (acc_q.size() > 0) ? acc_q[0] : '0, k);
    else n_pass++;
    n_chk++; if (valid_cyc != 1) $display("FAIL nom_valid_cycles: got %0d want 1", valid_cyc); else n_pass++;
    n_chk++; if (ferr_n != 0 || ovr_n != 0)
      $display("FAIL nom_pulses: got ferr=%0d ovr=%0d want 0 0", ferr_n, ovr_n); else n_pass++;
  endtask

  task automatic test_random();
    logic [NB-1:0] v;
    for (int f = 0; f < 3; f++) begin
      clear_mon();
      blk_ready = 1'b1;
      v = rnd_blk();
      send_frame(v);
      n_chk++; if (acc_q.size() != 1 || acc_q[0] !== v)
        $display("FAIL rnd_data%0d: got n=%0d %h want 1 %h", f, acc_q.size(), (acc_q.size() > 0) ? acc_q[0] : '0, v);
      else n_pass++;
    end
    blk_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [NB-1:0] a, b;
    clear_mon();
    blk_ready = 1'b0;
    a = rnd_blk(); b = rnd_blk();
    send_frame(a);
    send_frame(b);
    n_chk++; if (blk_valid !== 1'b1 || blk_data !== a)
      $display("FAIL bp_hold: got v=%b %h want 1 %h", blk_valid, blk_data, a); else n_pass++;
    n_chk++; if (ovr_n != 1) $display("FAIL bp_overrun: got %0d want 1", ovr_n); else n_pass++;
    accept_one();
    n_chk++; if (acc_q.size() != 1 || acc_q[0] !== a)
      $display("FAIL bp_deliver: got n=%0d %h want 1 %h", acc_q.size(), (acc_q.size() > 0) ? acc_q[0] : '0, a);
    else n_pass++;
    n_chk++; if (blk_valid !== 1'b0 || blk_data !== a)
      $display("FAIL bp_after_accept: got v=%b %h want 0 %h", blk_valid, blk_data, a); else n_pass++;
    n_chk++; if (stab_err != 0 || ferr_n != 0)
      $display("FAIL bp_stable: got stab=%0d ferr=%0d want 0 0", stab_err, ferr_n); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [NB-1:0] a, b;
    clear_mon();
    blk_ready = 1'b0;
    a = rnd_blk(); b = rnd_blk();
    send_frame(a);
    send_bits(b, NB - 1);
    // Last bit: sample lands SYNC_STAGES+1+SETTLE clocks after the toggle.
    ser_data = b[NB-1];
    ser_strobe = ~ser_strobe;
    tick(SS + 1 + ST - 1);
    blk_ready = 1'b1;
    tick(1);
    blk_ready = 1'b0;
    n_chk++; if (blk_valid !== 1'b1 || blk_data !== b)
      $display("FAIL b2b_load: got v=%b %h want 1 %h", blk_valid, blk_data, b); else n_pass++;
    tick(SP - (SS + 1 + ST));
    send_bit(1'($urandom_range(0, 1)));
    tick(GAP + 20);
    n_chk++; if (ovr_n != 0) $display("FAIL b2b_overrun: got %0d want 0", ovr_n); else n_pass++;
    n_chk++; if (acc_q.size() != 1 || acc_q[0] !== a)
      $display("FAIL b2b_first: got n=%0d want 1 block %h", acc_q.size(), a); else n_pass++;
    accept_one();
    n_chk++; if (acc_q.size() != 2 || acc_q[1] !== b)
      $display("FAIL b2b_second: got n=%0d want 2, second %h", acc_q.size(), b); else n_pass++;
  endtask

  task automatic test_truncation();
    logic [NB-1:0] v;
    int t0;
    clear_mon();
    blk_ready = 1'b1;
    v = rnd_blk();
    send_bits(v, 99);
    t0 = cyc;
    send_bit(v[99]);
    tick(GAP + 40);
    n_chk++; if (ferr_n != 1 || valid_cyc != 0 || busy !== 1'b0)
      $display("FAIL trunc_err: got ferr=%0d valid=%0d busy=%b want 1 0 0", ferr_n, valid_cyc, busy); else n_pass++;
    n_chk++; if (ferr_cyc < t0 + GAP || ferr_cyc > t0 + GAP + 10)
      $display("FAIL trunc_timing: got %0d cycles want %0d..%0d", ferr_cyc - t0, GAP, GAP + 10); else n_pass++;
    v = rnd_blk();
    send_frame(v);
    n_chk++; if (acc_q.size() != 1 || acc_q[0] !== v || ferr_n != 1)
      $display("FAIL trunc_next: got n=%0d ferr=%0d want 1 block %h, ferr 1", acc_q.size(), ferr_n, v); else n_pass++;
  endtask

  task automatic test_glitch();
    logic [NB-1:0] v;
    clear_mon();
    blk_ready = 1'b1;
    v = rnd_blk();
    send_bits(v, 50);
    ser_strobe = ~ser_strobe;
    tick(2);
    ser_strobe = ~ser_strobe;
    tick(12);
    n_chk++; if (ferr_n != 1 || busy !== 1'b0)
      $display("FAIL glitch_err: got ferr=%0d busy=%b want 1 0", ferr_n, busy); else n_pass++;
    tick(GAP + 20);
    v = rnd_blk();
    send_frame(v);
    n_chk++; if (acc_q.size() != 1 || acc_q[0] !== v || valid_cyc != 1)
      $display("FAIL glitch_next: got n=%0d valid=%0d want 1 1 block %h", acc_q.size(), valid_cyc, v); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [NB-1:0] v;
    clear_mon();
    blk_ready = 1'b0;
    v = rnd_blk();
    send_frame(v);
    n_chk++; if (blk_valid !== 1'b1) $display("FAIL rmid_pre: got %b want 1", blk_valid); else n_pass++;
    send_bits(rnd_blk(), 60);
    rst_n = 1'b0;
    #1;
    n_chk++; if (blk_valid !== 1'b0 || blk_data !== '0 || busy !== 1'b0)
      $display("FAIL rmid_clear: got v=%b d=%h busy=%b want 0 0 0", blk_valid, blk_data, busy); else n_pass++;
    ser_strobe = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(3);
    clear_mon();
    blk_ready = 1'b1;
    v = rnd_blk();
    send_frame(v);
    n_chk++; if (acc_q.size() != 1 || acc_q[0] !== v || ferr_n != 0)
      $display("FAIL rmid_next: got n=%0d ferr=%0d want 1 0 block %h", acc_q.size(), ferr_n, v); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_truncation();
    test_glitch();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
